vcve2_sleep_ctrl: RTL and testbench

VCVE2_SLEEP_CTRL -- requirements
Module: vcve2_sleep_ctrl

---
 rtl/vcve2_sleep_ctrl.sv | 111 +++++++++++
 tb/tb_vcve2_sleep_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vcve2_sleep_ctrl.sv
// Core sleep controller: drains the pipeline on WFI, gates the core clock while asleep,
// and runs a fixed wake-up sequence before releasing the core. Runs on the free-running clock.
module vcve2_sleep_ctrl #(
  parameter int unsigned WakeCycles = 2,
  parameter int unsigned DrainMax   = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fetch_enable_i,
  input  logic sleep_req_i,
  input  logic pipe_idle_i,
  input  logic irq_pending_i,
  input  logic debug_req_i,
  input  logic test_en_i,
  output logic clock_en_o,
  output logic core_sleep_o,
  output logic wake_o,
  output logic sleep_abort_o
);

  localparam int unsigned MaxCycles = (WakeCycles > DrainMax) ? WakeCycles : DrainMax;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] DrainLast = CntW'(DrainMax - 1);
  localparam logic [CntW-1:0] WakeLast  = CntW'(WakeCycles - 1);

  generate
    if (WakeCycles < 1 || DrainMax < 1) begin : g_bad_params
      $error("vcve2_sleep_ctrl: WakeCycles and DrainMax must both be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StRun   = 3'd1,
    StDrain = 3'd2,
    StSleep = 3'd3,
    StWake  = 3'd4
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              wake_q;
  logic              abort_q;
  logic              wake_evt;

  assign wake_evt = irq_pending_i | debug_req_i;

  // Counter is shared: DRAIN timeout and WAKE settle time never overlap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StBoot;
      cnt_q   <= '0;
      wake_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      wake_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        StBoot: begin
          if (fetch_enable_i) state_q <= StRun;
        end
        StRun: begin
          if (sleep_req_i && !wake_evt) begin
            state_q <= StDrain;
            cnt_q   <= '0;
          end
        end
        StDrain: begin
          if (wake_evt || !sleep_req_i) begin
            state_q <= StRun;
            abort_q <= 1'b1;
          end else if (pipe_idle_i) begin
            state_q <= StSleep;
          end else if (cnt_q == DrainLast) begin
            state_q <= StRun;
            abort_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StSleep: begin
          if (wake_evt) begin
            state_q <= StWake;
            cnt_q   <= '0;
          end
        end
        StWake: begin
          // Wake-up runs to completion regardless of wake_evt.
          if (cnt_q == WakeLast) begin
            state_q <= StRun;
            wake_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StBoot;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Only test_en_i may reach clock_en_o without passing through a register.
  assign clock_en_o    = (state_q == StRun) || (state_q == StDrain) || (state_q == StWake) ||
                         test_en_i;
  assign core_sleep_o  = (state_q == StSleep) || (state_q == StWake);
  assign wake_o        = wake_q;
  assign sleep_abort_o = abort_q;

endmodule

// File: tb/tb_vcve2_sleep_ctrl.sv
// Bench for vcve2_sleep_ctrl: per-scenario tasks push expected {clock_en, core_sleep, wake, abort}
// into a scoreboard queue and compare after each edge.
module tb_vcve2_sleep_ctrl;

  logic clk_i = 1'b0;
  logic rst_ni, fetch_enable_i, sleep_req_i, pipe_idle_i;
  logic irq_pending_i, debug_req_i, test_en_i;
  logic clock_en_o, core_sleep_o, wake_o, sleep_abort_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_v;
  logic [3:0]  got_v;

  vcve2_sleep_ctrl #(.WakeCycles(2), .DrainMax(16)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_enable_i(fetch_enable_i),
    .sleep_req_i   (sleep_req_i),
    .pipe_idle_i   (pipe_idle_i),
    .irq_pending_i (irq_pending_i),
    .debug_req_i   (debug_req_i),
    .test_en_i     (test_en_i),
    .clock_en_o    (clock_en_o),
    .core_sleep_o  (core_sleep_o),
    .wake_o        (wake_o),
    .sleep_abort_o (sleep_abort_o)
  );

  always #5 clk_i = ~clk_i;

  assign got_v = {clock_en_o, core_sleep_o, wake_o, sleep_abort_o};

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; fetch_enable_i = 1'b0; sleep_req_i = 1'b0; pipe_idle_i = 1'b0;
    irq_pending_i = 1'b0; debug_req_i = 1'b0; test_en_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(4'b0000);
      cyc();
      exp_v = exp_q.pop_front(); n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL reset[%0d] got=%b exp=%b", i, got_v, exp_v);
      end
    end
    test_en_i = 1'b1;
    exp_q.push_back(4'b1000);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL reset_scan got=%b exp=%b", got_v, exp_v);
    end
    test_en_i = 1'b0;
    cyc();
  endtask

  task automatic test_boot();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(4'b0000);
      cyc();
      exp_v = exp_q.pop_front(); n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL boot_wait[%0d] got=%b exp=%b", i, got_v, exp_v);
      end
    end
    fetch_enable_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(4'b1000);
      cyc();
      fetch_enable_i = 1'b0;
      exp_v = exp_q.pop_front(); n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL boot_run[%0d] got=%b exp=%b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_sleep_cycle();
    logic [3:0] seq[10];
    seq = '{4'b1000, 4'b1000, 4'b1000,  // three DRAIN cycles, pipe busy
            4'b0100, 4'b0100,           // SLEEP
            4'b1100, 4'b1100,           // WAKE (two cycles)
            4'b1010, 4'b1000, 4'b1000}; // RUN with one wake pulse
    sleep_req_i = 1'b1; pipe_idle_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) pipe_idle_i = 1'b1;
      if (i == 5) irq_pending_i = 1'b1;
      if (i == 6) begin irq_pending_i = 1'b0; sleep_req_i = 1'b0; pipe_idle_i = 1'b0; end
      exp_q.push_back(seq[i]);
      cyc();
      exp_v = exp_q.pop_front(); n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL sleep_cycle[%0d] got=%b exp=%b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_drain_timeout();
    sleep_req_i = 1'b1; pipe_idle_i = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i == 17) sleep_req_i = 1'b0;
      exp_q.push_back((i == 16) ? 4'b1001 : 4'b1000);
      cyc();
      exp_v = exp_q.pop_front(); n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL drain_timeout[%0d] got=%b exp=%b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] seq[7];
    seq = '{4'b1000,  // sleep+debug in RUN: stay
            4'b1000,  // request dropped: still RUN, no abort
            4'b1000,  // enter DRAIN
            4'b1001,  // idle+debug in DRAIN: abort
            4'b1000,  // enter DRAIN again
            4'b1001,  // sleep_req dropped: abort
            4'b1000};
    for (int i = 0; i < 7; i++) begin
      sleep_req_i = 1'b0; debug_req_i = 1'b0; pipe_idle_i = 1'b0;
      case (i)
        0: begin sleep_req_i = 1'b1; debug_req_i = 1'b1; end
        2, 4: sleep_req_i = 1'b1;
        3: begin sleep_req_i = 1'b1; pipe_idle_i = 1'b1; debug_req_i = 1'b1; end
        default: ;
      endcase
      exp_q.push_back(seq[i]);
      cyc();
      exp_v = exp_q.pop_front(); n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL simultaneous[%0d] got=%b exp=%b", i, got_v, exp_v);
      end
    end
    sleep_req_i = 1'b0; debug_req_i = 1'b0; pipe_idle_i = 1'b0;
  endtask

  task automatic test_scan_reset();
    sleep_req_i = 1'b1; pipe_idle_i = 1'b1;
    cyc();
    cyc();
    sleep_req_i = 1'b0; pipe_idle_i = 1'b0;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0100);
    exp_v = exp_q.pop_front(); n_vec++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL scan_sleep got=%b exp=%b", got_v, exp_v);
    end
    test_en_i = 1'b1;
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL scan_comb got=%b exp=%b", got_v, exp_v);
    end
    cyc();
    exp_v = exp_q.pop_front(); n_vec++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL scan_hold got=%b exp=%b", got_v, exp_v);
    end
    test_en_i = 1'b0;
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL scan_off got=%b exp=%b", got_v, exp_v);
    end
    irq_pending_i = 1'b1;
    exp_q.push_back(4'b1100);
    cyc();
    irq_pending_i = 1'b0;
    exp_v = exp_q.pop_front(); n_vec++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL wake_entry got=%b exp=%b", got_v, exp_v);
    end
    rst_ni = 1'b0;
    exp_q.push_back(4'b0000);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (got_v !== exp_v) begin
      n_err++; $display("FAIL wake_reset got=%b exp=%b", got_v, exp_v);
    end
    cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) fetch_enable_i = 1'b1;
      exp_q.push_back((i == 3) ? 4'b1000 : 4'b0000);
      cyc();
      exp_v = exp_q.pop_front(); n_vec++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL post_reset[%0d] got=%b exp=%b", i, got_v, exp_v);
      end
    end
    fetch_enable_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_sleep_cycle();
    test_drain_timeout();
    test_simultaneous();
    test_scan_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
